// File: rtl/game_io_regs_pkg.sv
// game_io_pkg: port map, interrupt bit indices and LFSR step shared by the game I/O block
package game_io_pkg;

    localparam logic [7:0] PORT_BTNS    = 8'h00;
    localparam logic [7:0] PORT_SW      = 8'h01;
    localparam logic [7:0] PORT_LED     = 8'h02;
    localparam logic [7:0] PORT_DIG3    = 8'h03;
    localparam logic [7:0] PORT_DIG2    = 8'h04;
    localparam logic [7:0] PORT_DIG1    = 8'h05;
    localparam logic [7:0] PORT_DIG0    = 8'h06;
    localparam logic [7:0] PORT_DP      = 8'h07;
    localparam logic [7:0] PORT_CAUSE   = 8'h08;
    localparam logic [7:0] PORT_INFO    = 8'h09;
    localparam logic [7:0] PORT_IRQ_EN  = 8'h0A;
    localparam logic [7:0] PORT_IRQ_CLR = 8'h0B;
    localparam logic [7:0] PORT_EDGES   = 8'h0C;
    localparam logic [7:0] PORT_PEND    = 8'h0D;
    localparam logic [7:0] PORT_RAND    = 8'h0F;

    localparam int IRQ_BTN  = 0;
    localparam int IRQ_TICK = 1;
    localparam int NUM_IRQ  = 2;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;

    // Galois right-shift step; the all-zero state maps to itself, so it must never be loaded
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/game_io_regs_if.sv
// game_io_regs_if: KCPSM6 port bus and interrupt handshake
interface game_io_regs_if;

    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
        output in_port, interrupt
    );

endinterface

// File: rtl/game_io_regs_lfsr.sv
// game_lfsr: free-running 8-bit maximal-length Galois LFSR
module game_lfsr
    import game_io_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    // Shift every cycle; a zero seed is replaced so the sequence cannot lock up
    always_ff @(posedge clk) begin
        value <= reset ? INIT : lfsr_next(value);
    end

endmodule

// File: rtl/game_io_regs.sv
// game_io_regs: KCPSM6 port-mapped display/LED registers, input readback and interrupt controller
module game_io_regs
    import game_io_pkg::*;
#(
    parameter int         NUM_BTNS    = 4,
    parameter int         TICK_CYCLES = 1_666_666,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    game_io_regs_if.slave       bus,
    input  logic [NUM_BTNS-1:0] db_btns,
    input  logic [7:0]          db_sw,
    output logic [7:0]          led,
    output logic [4:0]          dig3,
    output logic [4:0]          dig2,
    output logic [4:0]          dig1,
    output logic [4:0]          dig0,
    output logic [3:0]          dp,
    output logic [7:0]          game_info
);

    localparam int            CW        = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    logic [NUM_BTNS-1:0] btn_prev;
    logic [7:0]          btn_edges;
    logic [7:0]          new_edges;
    logic [7:0]          edges_nxt;
    logic [7:0]          rd_data;
    logic [7:0]          lfsr;
    logic [CW-1:0]       tick_cnt;
    irq_vec_t            irq_en;
    irq_vec_t            pending;
    irq_vec_t            irq_cause;
    irq_vec_t            events;
    irq_vec_t            active;
    irq_vec_t            clr;
    irq_vec_t            pending_nxt;
    logic                tick;
    logic                wr;
    logic                unused;

    // Constant-port writes carry nothing this block decodes
    assign unused = bus.k_write_strobe;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    // Event detection and next values; new events override any clear in the same cycle
    always_comb begin
        wr               = bus.write_strobe;
        new_edges        = 8'(db_btns & ~btn_prev);
        tick             = tick_cnt == TICK_LAST;
        events           = '0;
        events[IRQ_BTN]  = |new_edges;
        events[IRQ_TICK] = tick;
        active           = pending & irq_en;
        clr              = (bus.interrupt_ack ? active : '0)
                         | ((wr && bus.port_id == PORT_IRQ_CLR) ? bus.out_port[NUM_IRQ-1:0] : '0);
        pending_nxt      = (pending & ~clr) | events;
        edges_nxt        = ((bus.read_strobe && bus.port_id == PORT_EDGES) ? 8'h00 : btn_edges) | new_edges;
    end

    // Read decode, registered into in_port below
    always_comb begin
        rd_data = 8'h00;
        case (bus.port_id)
            PORT_BTNS:  rd_data = 8'(db_btns);
            PORT_SW:    rd_data = db_sw;
            PORT_CAUSE: rd_data = 8'(irq_cause);
            PORT_EDGES: rd_data = btn_edges;
            PORT_PEND:  rd_data = 8'(pending);
            PORT_RAND:  rd_data = lfsr;
            default:    rd_data = 8'h00;
        endcase
    end

    // Output registers written by the CPU, plus the registered read path
    always_ff @(posedge clk) begin
        if (reset) begin
            led         <= 8'h00;
            dig3        <= 5'h00;
            dig2        <= 5'h00;
            dig1        <= 5'h00;
            dig0        <= 5'h00;
            dp          <= 4'h0;
            game_info   <= 8'h00;
            irq_en      <= '0;
            bus.in_port <= 8'h00;
        end else begin
            bus.in_port <= rd_data;
            if (wr) begin
                case (bus.port_id)
                    PORT_LED:    led       <= bus.out_port;
                    PORT_DIG3:   dig3      <= bus.out_port[4:0];
                    PORT_DIG2:   dig2      <= bus.out_port[4:0];
                    PORT_DIG1:   dig1      <= bus.out_port[4:0];
                    PORT_DIG0:   dig0      <= bus.out_port[4:0];
                    PORT_DP:     dp        <= bus.out_port[3:0];
                    PORT_INFO:   game_info <= bus.out_port;
                    PORT_IRQ_EN: irq_en    <= bus.out_port[NUM_IRQ-1:0];
                    default:     ;
                endcase
            end
        end
    end

    // Interrupt controller state: edge history, frame tick, pending/cause and the request line
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev      <= '0;
            btn_edges     <= 8'h00;
            tick_cnt      <= '0;
            pending       <= '0;
            irq_cause     <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            btn_prev      <= db_btns;
            btn_edges     <= edges_nxt;
            tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;
            pending       <= pending_nxt;
            irq_cause     <= bus.interrupt_ack ? active : irq_cause;
            bus.interrupt <= bus.interrupt_ack ? 1'b0 : |active;
        end
    end

endmodule

// File: tb/tb_game_io_regs.sv
// tb_game_io_regs: table-driven write checks plus scoreboarded read/interrupt sequences
module tb_game_io_regs;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] db_btns = 4'h0;
    logic [7:0] db_sw = 8'h00;
    logic [7:0] led, game_info;
    logic [4:0] dig3, dig2, dig1, dig0;
    logic [3:0] dp;

    game_io_regs_if bus();

    game_io_regs #(.NUM_BTNS(4), .TICK_CYCLES(10), .LFSR_SEED(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .db_btns   (db_btns),
        .db_sw     (db_sw),
        .led       (led),
        .dig3      (dig3),
        .dig2      (dig2),
        .dig1      (dig1),
        .dig0      (dig0),
        .dp        (dp),
        .game_info (game_info)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] exp;
    } sb_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       ws;
        logic [7:0] led;
        logic [4:0] d3;
        logic [4:0] d2;
        logic [4:0] d1;
        logic [4:0] d0;
        logic [3:0] dp;
        logic [7:0] info;
    } wv_t;

    sb_t  q[$];
    wv_t  tbl[11];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic seen[256];
    logic [7:0] m;
    int   distinct;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input string name, input logic [39:0] exp);
        q.push_back('{name, exp});
    endtask

    task automatic pop_chk(input logic [39:0] act);
        sb_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 40'd1, 40'd0);
        end else begin
            e = q.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] mask, input logic [7:0] exp, input string name);
        push(name, 40'(exp));
        bus.port_id = addr;
        step();
        pop_chk(40'(bus.in_port & mask));
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id = addr;
        bus.out_port = data;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [39:0] outs();
        return {led, dig3, dig2, dig1, dig0, dp, game_info};
    endfunction

    initial begin
        bus.port_id = 8'h00;
        bus.out_port = 8'h00;
        bus.write_strobe = 1'b0;
        bus.k_write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        bus.interrupt_ack = 1'b0;

        tbl[0]  = '{8'h02, 8'h5A, 1'b1, 8'h5A, 5'h00, 5'h00, 5'h00, 5'h00, 4'h0, 8'h00};
        tbl[1]  = '{8'h07, 8'hFF, 1'b1, 8'h5A, 5'h00, 5'h00, 5'h00, 5'h00, 4'hF, 8'h00};
        tbl[2]  = '{8'h11, 8'h33, 1'b1, 8'h5A, 5'h00, 5'h00, 5'h00, 5'h00, 4'hF, 8'h00};
        tbl[3]  = '{8'h03, 8'h1F, 1'b1, 8'h5A, 5'h1F, 5'h00, 5'h00, 5'h00, 4'hF, 8'h00};
        tbl[4]  = '{8'h04, 8'hE2, 1'b1, 8'h5A, 5'h1F, 5'h02, 5'h00, 5'h00, 4'hF, 8'h00};
        tbl[5]  = '{8'h05, 8'h0A, 1'b1, 8'h5A, 5'h1F, 5'h02, 5'h0A, 5'h00, 4'hF, 8'h00};
        tbl[6]  = '{8'h06, 8'h35, 1'b1, 8'h5A, 5'h1F, 5'h02, 5'h0A, 5'h15, 4'hF, 8'h00};
        tbl[7]  = '{8'h09, 8'hC7, 1'b1, 8'h5A, 5'h1F, 5'h02, 5'h0A, 5'h15, 4'hF, 8'hC7};
        tbl[8]  = '{8'h0E, 8'hFF, 1'b1, 8'h5A, 5'h1F, 5'h02, 5'h0A, 5'h15, 4'hF, 8'hC7};
        tbl[9]  = '{8'h07, 8'h00, 1'b0, 8'h5A, 5'h1F, 5'h02, 5'h0A, 5'h15, 4'hF, 8'hC7};
        tbl[10] = '{8'h02, 8'h00, 1'b1, 8'h00, 5'h1F, 5'h02, 5'h0A, 5'h15, 4'hF, 8'hC7};

        do_reset();
        chk("rst_outs", outs(), 40'd0);
        chk("rst_irq", 40'(bus.interrupt), 40'd0);
        chk("rst_in_port", 40'(bus.in_port), 40'd0);

        for (int i = 0; i < 11; i++) begin
            push($sformatf("wr_vec%0d", i), {tbl[i].led, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0, tbl[i].dp, tbl[i].info});
            bus.port_id = tbl[i].addr;
            bus.out_port = tbl[i].data;
            bus.write_strobe = tbl[i].ws;
            bus.k_write_strobe = ~tbl[i].ws;
            step();
            bus.write_strobe = 1'b0;
            bus.k_write_strobe = 1'b0;
            pop_chk(outs());
        end

        db_sw = 8'hC3;
        rd(8'h01, 8'hFF, 8'hC3, "rd_sw");
        rd(8'h0E, 8'hFF, 8'h00, "rd_unmapped");
        db_btns = 4'hA;
        rd(8'h00, 8'hFF, 8'h0A, "rd_btns");
        db_btns = 4'h0;
        rd(8'h08, 8'hFF, 8'h00, "rd_cause_rst");

        do_reset();
        bus.port_id = 8'h0D;
        for (int k = 1; k <= 11; k++) begin
            push($sformatf("tick_c%0d", k), (k == 11) ? 40'h02 : 40'h00);
            step();
            pop_chk(40'(bus.in_port));
        end
        for (int k = 0; k < 20 && cyc < 19; k++) step();
        wr(8'h0B, 8'h02);
        rd(8'h0D, 8'hFF, 8'h02, "w1c_vs_tick");
        wr(8'h0B, 8'h02);
        rd(8'h0D, 8'hFF, 8'h00, "w1c_clear");

        db_btns = 4'h1;
        step();
        db_btns = 4'h0;
        step();
        step();
        chk("gate_irq", 40'(bus.interrupt), 40'd0);
        rd(8'h0D, 8'h01, 8'h01, "pend_no_en");
        wr(8'h0B, 8'h01);
        rd(8'h0D, 8'h01, 8'h00, "w1c_btn");
        bus.read_strobe = 1'b1;
        rd(8'h0C, 8'hFF, 8'h01, "edges_gate");
        bus.read_strobe = 1'b0;

        wr(8'h0A, 8'h01);
        db_btns = 4'h4;
        step();
        chk("irq_n1", 40'(bus.interrupt), 40'd0);
        db_btns = 4'h0;
        step();
        chk("irq_n2", 40'(bus.interrupt), 40'd1);
        bus.interrupt_ack = 1'b1;
        step();
        bus.interrupt_ack = 1'b0;
        chk("ack_deassert", 40'(bus.interrupt), 40'd0);
        rd(8'h08, 8'hFF, 8'h01, "cause_btn");
        rd(8'h0C, 8'hFF, 8'h04, "edges_btn");
        bus.read_strobe = 1'b1;
        rd(8'h0C, 8'hFF, 8'h04, "edges_rd_old");
        bus.read_strobe = 1'b0;
        rd(8'h0C, 8'hFF, 8'h00, "edges_cleared");
        chk("irq_idle", 40'(bus.interrupt), 40'd0);

        db_btns = 4'h2;
        step();
        db_btns = 4'h0;
        step();
        chk("irq2", 40'(bus.interrupt), 40'd1);
        db_btns = 4'h8;
        bus.interrupt_ack = 1'b1;
        step();
        bus.interrupt_ack = 1'b0;
        chk("ack_edge_deassert", 40'(bus.interrupt), 40'd0);
        step();
        chk("irq_reassert", 40'(bus.interrupt), 40'd1);
        rd(8'h08, 8'hFF, 8'h01, "cause_ack_edge");
        rd(8'h0D, 8'h01, 8'h01, "pend_after_ack_edge");
        rd(8'h0C, 8'hFF, 8'h0A, "edges_two");

        db_btns = 4'h0;
        wr(8'h02, 8'hA5);
        chk("led_pre_rst", 40'(led), 40'hA5);
        chk("irq_pre_rst", 40'(bus.interrupt), 40'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        chk("rst_mid_irq", 40'(bus.interrupt), 40'd0);
        chk("rst_mid_outs", outs(), 40'd0);
        rd(8'h0D, 8'hFF, 8'h00, "rst_mid_pend");
        bus.interrupt_ack = 1'b1;
        step();
        bus.interrupt_ack = 1'b0;
        rd(8'h08, 8'hFF, 8'h00, "cause_after_rst");

        do_reset();
        bus.port_id = 8'h0F;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        m = 8'h01;
        distinct = 0;
        for (int i = 0; i < 256; i++) begin
            push((i == 0) ? "lfsr_first" : $sformatf("lfsr_s%0d", i), 40'(m));
            step();
            pop_chk(40'(bus.in_port));
            if (i < 255 && !seen[bus.in_port]) begin
                seen[bus.in_port] = 1'b1;
                if (bus.in_port != 8'h00) distinct++;
            end
            m = {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00);
        end
        chk("lfsr_distinct", 40'(distinct), 40'd255);
        chk("lfsr_zero_seen", 40'(seen[0]), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
